// File: rtl/ci_issue_sequencer.sv
// Custom-instruction issue sequencer: buffers operands, issues one per cycle to a fixed-latency unit,
// collects in-order results. Define CI_ISSUE_PERF_EN to add issue/completion/busy counters.
module ci_issue_sequencer #(
    parameter int DATA_W    = 32,
    parameter int OP_DEPTH  = 4,
    parameter int RES_DEPTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              clk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ci_clk_en,
    output logic              ci_aclr,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    input  logic [DATA_W-1:0] ci_result,
    input  logic              ci_done,
    output logic              busy,
`ifdef CI_ISSUE_PERF_EN
    output logic [15:0]       perf_issued,
    output logic [15:0]       perf_completed,
    output logic [23:0]       perf_busy_cycles,
`endif
    output logic              err_timeout
);
    localparam int OP_AW  = $clog2(OP_DEPTH);
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int CNT_W  = RES_AW + 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] op_mem_q  [OP_DEPTH];
    logic [DATA_W-1:0] res_mem_q [RES_DEPTH];

    logic [OP_AW-1:0]  op_wr_q, op_wr_d, op_rd_q, op_rd_d;
    logic [OP_AW:0]    op_cnt_q, op_cnt_d;
    logic [RES_AW-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              aclr_hold_q, aclr_hold_d;
    logic              ci_start_q, ci_start_d;
    logic [DATA_W-1:0] ci_dataa_q, ci_dataa_d;
`ifdef CI_ISSUE_PERF_EN
    logic [15:0]       perf_issued_q, perf_issued_d;
    logic [15:0]       perf_completed_q, perf_completed_d;
    logic [23:0]       perf_busy_q, perf_busy_d;
`endif

    logic op_full, op_push, issue, done_acc, res_pop, abort, credit_ok;

    always_comb begin
        op_full   = (op_cnt_q == (OP_AW+1)'(OP_DEPTH));
        in_ready  = aclr_n && !op_full;
        out_valid = aclr_n && (res_cnt_q != '0);
        busy      = aclr_n && ((op_cnt_q != '0) || (outstanding_q != '0));
        op_push   = clk_en && in_valid && in_ready;
        done_acc  = clk_en && ci_done && (outstanding_q != '0);
        res_pop   = clk_en && out_valid && out_ready;
        // Results in the FIFO plus those still in the unit may never exceed the FIFO size.
        credit_ok = ({1'b0, outstanding_q} + {1'b0, res_cnt_q}) < (CNT_W+1)'(RES_DEPTH);
        abort     = clk_en && (outstanding_q != '0) && !ci_done && (tmo_q == TMO_W'(TIMEOUT - 1));
        issue     = clk_en && (op_cnt_q != '0) && credit_ok && !abort;

        op_wr_d  = op_wr_q + OP_AW'(op_push);
        op_rd_d  = abort ? op_wr_q : op_rd_q + OP_AW'(issue);
        op_cnt_d = abort ? (OP_AW+1)'(op_push)
                         : op_cnt_q + (OP_AW+1)'(op_push) - (OP_AW+1)'(issue);

        res_wr_d  = res_wr_q + RES_AW'(done_acc);
        res_rd_d  = res_rd_q + RES_AW'(res_pop);
        res_cnt_d = res_cnt_q + CNT_W'(done_acc) - CNT_W'(res_pop);

        outstanding_d = abort ? '0 : outstanding_q + CNT_W'(issue) - CNT_W'(done_acc);
        tmo_d         = (done_acc || (outstanding_q == '0) || abort) ? '0 : tmo_q + 1'b1;
        err_d         = err_q || abort;
        aclr_hold_d   = abort;
        ci_start_d    = issue;
        ci_dataa_d    = issue ? op_mem_q[op_rd_q] : ci_dataa_q;
`ifdef CI_ISSUE_PERF_EN
        perf_issued_d    = perf_issued_q + 16'(issue);
        perf_completed_d = perf_completed_q + 16'(done_acc);
        perf_busy_d      = perf_busy_q + 24'(busy);
`endif
    end

    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            op_wr_q       <= '0;
            op_rd_q       <= '0;
            op_cnt_q      <= '0;
            res_wr_q      <= '0;
            res_rd_q      <= '0;
            res_cnt_q     <= '0;
            outstanding_q <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            aclr_hold_q   <= 1'b1;
            ci_start_q    <= 1'b0;
            ci_dataa_q    <= '0;
`ifdef CI_ISSUE_PERF_EN
            perf_issued_q    <= '0;
            perf_completed_q <= '0;
            perf_busy_q      <= '0;
`endif
        end else if (clk_en) begin
            op_wr_q       <= op_wr_d;
            op_rd_q       <= op_rd_d;
            op_cnt_q      <= op_cnt_d;
            res_wr_q      <= res_wr_d;
            res_rd_q      <= res_rd_d;
            res_cnt_q     <= res_cnt_d;
            outstanding_q <= outstanding_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            aclr_hold_q   <= aclr_hold_d;
            ci_start_q    <= ci_start_d;
            ci_dataa_q    <= ci_dataa_d;
`ifdef CI_ISSUE_PERF_EN
            perf_issued_q    <= perf_issued_d;
            perf_completed_q <= perf_completed_d;
            perf_busy_q      <= perf_busy_d;
`endif
        end
    end

    // Storage arrays need no reset; pointers and counts define what is valid.
    always_ff @(posedge clock) begin
        if (aclr_n && op_push)
            op_mem_q[op_wr_q] <= in_data;
        if (aclr_n && done_acc)
            res_mem_q[res_wr_q] <= ci_result;
    end

    always_comb begin
        out_data    = res_mem_q[res_rd_q];
        ci_clk_en   = clk_en;
        ci_aclr     = !aclr_n || aclr_hold_q;
        ci_start    = aclr_n && clk_en && ci_start_q;
        ci_dataa    = aclr_n ? ci_dataa_q : '0;
        err_timeout = err_q;
`ifdef CI_ISSUE_PERF_EN
        perf_issued      = perf_issued_q;
        perf_completed   = perf_completed_q;
        perf_busy_cycles = perf_busy_q;
`endif
    end

endmodule

// File: tb/tb_ci_issue_sequencer.sv
// Directed bench for ci_issue_sequencer with a latency-10 inverting stub unit.
module tb_ci_issue_sequencer;
    localparam int DATA_W = 32;
    localparam int LAT    = 10;

    logic              clock = 1'b0;
    logic              aclr_n = 1'b0;
    logic              clk_en = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              ci_clk_en, ci_aclr, ci_start, ci_done, busy, err_timeout;
    logic [DATA_W-1:0] ci_dataa, ci_result;
`ifdef CI_ISSUE_PERF_EN
    logic [15:0] perf_issued, perf_completed;
    logic [23:0] perf_busy_cycles;
`endif

    ci_issue_sequencer dut (
        .clock(clock), .aclr_n(aclr_n), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ci_clk_en(ci_clk_en), .ci_aclr(ci_aclr), .ci_start(ci_start), .ci_dataa(ci_dataa),
        .ci_result(ci_result), .ci_done(ci_done), .busy(busy),
`ifdef CI_ISSUE_PERF_EN
        .perf_issued(perf_issued), .perf_completed(perf_completed),
        .perf_busy_cycles(perf_busy_cycles),
`endif
        .err_timeout(err_timeout)
    );

    initial forever #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Stub unit: ignores ci_aclr so late completions really reach the DUT.
    logic [LAT-1:0]    stub_v = '0;
    logic [DATA_W-1:0] stub_d [LAT];
    logic              stub_mute = 1'b0;
    always @(posedge clock) begin
        if (ci_clk_en) begin
            stub_v    <= {stub_v[LAT-2:0], ci_start};
            stub_d[0] <= ci_dataa ^ 32'hFFFFFFFF;
            for (int i = 1; i < LAT; i++) stub_d[i] <= stub_d[i-1];
        end
    end
    assign ci_done   = stub_v[LAT-1] && !stub_mute;
    assign ci_result = stub_d[LAT-1];

    logic [DATA_W-1:0] feed_q[$];
    int                feed_idx = 0;
    int                acc_cyc[$];
    logic [DATA_W-1:0] st_q[$];
    int                st_cyc[$];
    logic [DATA_W-1:0] got_q[$];
    int                got_cyc[$];
    int nchk = 0;
    int nfail = 0;

    // Operand driver: presents feed_q in order, advancing on accepted handshakes.
    initial forever begin
        @(negedge clock); #4;
        if (feed_idx < feed_q.size()) begin
            in_valid = 1'b1;
            in_data  = feed_q[feed_idx];
        end else begin
            in_valid = 1'b0;
        end
        if (in_valid && in_ready && clk_en) begin
            acc_cyc.push_back(cyc);
            feed_idx++;
        end
    end

    initial forever begin
        @(negedge clock); #4;
        if (ci_start) begin st_q.push_back(ci_dataa); st_cyc.push_back(cyc); end
        if (out_valid && out_ready && clk_en) begin got_q.push_back(out_data); got_cyc.push_back(cyc); end
    end

    task automatic clear_logs;
        feed_q.delete(); feed_idx = 0; acc_cyc.delete();
        st_q.delete(); st_cyc.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic wait_got(input int n, input int bound);
        for (int i = 0; i < bound && got_q.size() < n; i++) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        aclr_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        nchk++; if (ci_start !== 1'b0 || ci_dataa !== 32'h0) begin nfail++; $display("FAIL reset_ci_start got=%0b/%h exp=0/0", ci_start, ci_dataa); end
        nchk++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin nfail++; $display("FAIL reset_busy_err got=%0b/%0b exp=0/0", busy, err_timeout); end
        nchk++; if (ci_aclr !== 1'b1) begin nfail++; $display("FAIL reset_ci_aclr got=%0b exp=1", ci_aclr); end
        aclr_n = 1'b1;
        #1;
        nchk++; if (ci_aclr !== 1'b1) begin nfail++; $display("FAIL reset_aclr_hold got=%0b exp=1", ci_aclr); end
        @(negedge clock);
        nchk++; if (ci_aclr !== 1'b0 || in_ready !== 1'b1) begin nfail++; $display("FAIL reset_release got aclr=%0b rdy=%0b exp 0/1", ci_aclr, in_ready); end
    endtask

    task automatic test_single;
        clear_logs();
        feed_q.push_back(32'h3F800000);
        wait_got(1, 40);
        nchk++;
        if (st_q.size() != 1 || acc_cyc.size() != 1) begin nfail++; $display("FAIL single_starts got=%0d exp=1", st_q.size()); end
        else if (st_q[0] !== 32'h3F800000 || st_cyc[0] != acc_cyc[0] + 2) begin nfail++;
            $display("FAIL single_issue got=%h lat=%0d exp=3f800000 lat=2", st_q[0], st_cyc[0] - acc_cyc[0]); end
        nchk++;
        if (got_q.size() != 1) begin nfail++; $display("FAIL single_out_count got=%0d exp=1", got_q.size()); end
        else if (got_q[0] !== 32'hC07FFFFF || st_cyc.size() != 1 || got_cyc[0] != st_cyc[0] + 11) begin nfail++;
            $display("FAIL single_result got=%h exp=c07fffff (cycles after start got=%0d exp=11)", got_q[0], got_cyc[0] - st_cyc[0]); end
        nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL single_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_streaming;
        logic [DATA_W-1:0] exp [8];
        exp = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB,
                32'hFFFFFFFA, 32'hFFFFFFF9, 32'hFFFFFFF8, 32'hFFFFFFF7};
        clear_logs();
        for (int i = 1; i <= 8; i++) feed_q.push_back(DATA_W'(i));
        wait_got(8, 80);
        nchk++;
        if (st_q.size() != 8) begin nfail++; $display("FAIL stream_starts got=%0d exp=8", st_q.size()); end
        else for (int i = 1; i < 8; i++)
            if (st_cyc[i] != st_cyc[0] + i) begin nfail++; $display("FAIL stream_start_gap idx=%0d got=%0d exp=%0d", i, st_cyc[i] - st_cyc[0], i); break; end
        nchk++;
        if (got_q.size() != 8) begin nfail++; $display("FAIL stream_out_count got=%0d exp=8", got_q.size()); end
        else for (int i = 0; i < 8; i++)
            if (got_q[i] !== exp[i] || got_cyc[i] != got_cyc[0] + i) begin nfail++;
                $display("FAIL stream_out idx=%0d got=%h exp=%h gap=%0d", i, got_q[i], exp[i], got_cyc[i] - got_cyc[0]); break; end
    endtask

    task automatic test_backpressure;
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) feed_q.push_back(32'h100 + DATA_W'(i));
        repeat (60) @(negedge clock);
        nchk++; if (st_q.size() != 16) begin nfail++; $display("FAIL bp_issues got=%0d exp=16", st_q.size()); end
        nchk++; if (in_ready !== 1'b0 || feed_idx != 20) begin nfail++; $display("FAIL bp_in_ready got=%0b accepted=%0d exp=0/20", in_ready, feed_idx); end
        nchk++; if (out_valid !== 1'b1 || got_q.size() != 0) begin nfail++; $display("FAIL bp_hold got=%0b/%0d exp=1/0", out_valid, got_q.size()); end
        out_ready = 1'b1;
        wait_got(20, 120);
        nchk++;
        if (got_q.size() != 20 || st_q.size() != 20) begin nfail++; $display("FAIL bp_drain got=%0d issued=%0d exp=20", got_q.size(), st_q.size()); end
        else for (int i = 0; i < 20; i++)
            if (got_q[i] !== (32'hFFFFFEFF - DATA_W'(i))) begin nfail++;
                $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], 32'hFFFFFEFF - DATA_W'(i)); break; end
    endtask

    task automatic test_timeout;
        int err_cyc;
        bit seen;
        clear_logs();
        stub_mute = 1'b1;
        feed_q.push_back(32'hDEADBEEF);
        for (int i = 0; i < 10 && st_q.size() < 1; i++) @(negedge clock);
        seen = 0; err_cyc = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (err_timeout === 1'b1) begin seen = 1; err_cyc = cyc; break; end
        end
        nchk++;
        if (!seen || st_cyc.size() != 1) begin nfail++; $display("FAIL tmo_flag got=%0b exp=1", err_timeout); end
        else if (err_cyc - st_cyc[0] != 64) begin nfail++; $display("FAIL tmo_delay got=%0d exp=64", err_cyc - st_cyc[0]); end
        nchk++; if (ci_aclr !== 1'b1 || busy !== 1'b0) begin nfail++; $display("FAIL tmo_abort got aclr=%0b busy=%0b exp 1/0", ci_aclr, busy); end
        @(negedge clock);
        nchk++; if (ci_aclr !== 1'b0) begin nfail++; $display("FAIL tmo_aclr_pulse got=%0b exp=0", ci_aclr); end
        stub_mute = 1'b0;
        clear_logs();
        feed_q.push_back(32'h12345678);
        wait_got(1, 40);
        nchk++;
        if (got_q.size() != 1 || got_q[0] !== 32'hEDCBA987 || err_timeout !== 1'b1) begin nfail++;
            $display("FAIL tmo_recover got n=%0d err=%0b exp n=1 data=edcba987 err=1", got_q.size(), err_timeout); end
    endtask

    task automatic test_midreset;
        clear_logs();
        feed_q.push_back(32'h11); feed_q.push_back(32'h22); feed_q.push_back(32'h33);
        for (int i = 0; i < 20 && st_q.size() < 3; i++) @(negedge clock);
        @(negedge clock);
        aclr_n = 1'b0;
        #1;
        nchk++; if (ci_aclr !== 1'b1) begin nfail++; $display("FAIL mrst_aclr_c1 got=%0b exp=1", ci_aclr); end
        @(negedge clock);
        aclr_n = 1'b1;
        #1;
        nchk++; if (ci_aclr !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0) begin nfail++;
            $display("FAIL mrst_c2 got aclr=%0b busy=%0b err=%0b exp 1/0/0", ci_aclr, busy, err_timeout); end
        @(negedge clock);
        nchk++; if (ci_aclr !== 1'b0) begin nfail++; $display("FAIL mrst_aclr_end got=%0b exp=0", ci_aclr); end
        repeat (20) @(negedge clock);
        nchk++; if (got_q.size() != 0 || out_valid !== 1'b0) begin nfail++;
            $display("FAIL mrst_late_done got n=%0d valid=%0b exp 0/0", got_q.size(), out_valid); end
    endtask

    task automatic test_clken;
        int n_st, n_got;
        clear_logs();
        for (int i = 0; i < 8; i++) feed_q.push_back(32'hA0 + DATA_W'(i));
        for (int i = 0; i < 20 && st_q.size() < 3; i++) @(negedge clock);
        @(negedge clock);
        clk_en = 1'b0;
        n_st = st_q.size(); n_got = got_q.size();
        repeat (5) @(negedge clock);
        #1;
        nchk++; if (st_q.size() != n_st || ci_start !== 1'b0 || ci_clk_en !== 1'b0) begin nfail++;
            $display("FAIL clken_freeze got starts=%0d start=%0b exp starts=%0d start=0", st_q.size(), ci_start, n_st); end
        nchk++; if (got_q.size() != n_got) begin nfail++; $display("FAIL clken_out got=%0d exp=%0d", got_q.size(), n_got); end
        clk_en = 1'b1;
        wait_got(8, 80);
        nchk++;
        if (got_q.size() != 8 || st_q.size() != 8) begin nfail++; $display("FAIL clken_count got=%0d issued=%0d exp=8", got_q.size(), st_q.size()); end
        else for (int i = 0; i < 8; i++)
            if (got_q[i] !== (32'hFFFFFF5F - DATA_W'(i))) begin nfail++;
                $display("FAIL clken_order idx=%0d got=%h exp=%h", i, got_q[i], 32'hFFFFFF5F - DATA_W'(i)); break; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_timeout();
        test_midreset();
        test_clken();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
